ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-client arbiter that shares one simple dual-port RAM (one write port, one read port, one-cycle registered read) between client A and client B, such as game-state logic and a display scanner. Each cycle it grants at most one write and at most one read, resolves contention round-robin per port, and prevents same-address read/write collisions. It then returns read data to the client that issued the read. It sits between the clients and the RAM instance, in the same clock domain as both.

## Interface
Parameters:
- SIZE, 8, RAM word width in bits.
- DEPTH, 8, RAM entry count; ADDR_W = $clog2(DEPTH).

Ports:
- clk  in  1  system clock; the arbiter and the RAM both use it (RAM wclk = rclk = clk).
- rst_n  in  1  asynchronous, active-low reset.
- a_req, b_req  in  1  request is valid; held stable until granted.
- a_we, b_we  in  1  1 = write request, 0 = read request.
- a_addr, b_addr  in  ADDR_W  target address.
- a_wdata, b_wdata  in  SIZE  write data.
- a_gnt, b_gnt  out  1  combinational; request accepted this cycle.
- a_rvalid, b_rvalid  out  1  registered; read data valid for that client.
- a_rdata, b_rdata  out  SIZE  read data; equals ram_rdata, qualified by rvalid.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_wdata  out  SIZE  RAM write data.
- ram_raddr  out  ADDR_W  RAM read address.
- ram_rdata  in  SIZE  RAM read data, valid one cycle after ram_raddr.

## Operation
- **Write port.** Write candidates are the clients with req=1 and we=1.
  - One candidate: it is granted.
  - Two candidates: the client not named by wptr is granted.
- **Read port.** Read candidates are the clients with req=1 and we=0. Arbitration is the same as the write port, using rptr.
- **Priority pointers.** wptr and rptr are 1-bit registers; 0 = A, 1 = B.
  - Each pointer is loaded with the granted client's index on every grant on its port.
  - Both pointers reset to 1, so A wins the first contention.
- **Collision rule.** If the granted write and the granted read target the same address in the same cycle, the write proceeds and the read grant is withheld.
  - The read is retried on the next cycle.
  - rptr does not change on a withheld read.
- **Mixed requests.** When one client writes and the other reads at different addresses, both are granted in the same cycle.
- **Idle port outputs.**
  - ram_we = 1 only when a write is granted.
  - ram_waddr and ram_wdata are muxed from the granted writer, or from A when the write port is idle.
  - ram_raddr is muxed from the granted reader, or from A when the read port is idle.
- **Read tracking.** A registered rd_pending bit and rd_tag (0 = A, 1 = B) track the read granted in the previous cycle.
  - The next cycle, a_rvalid = rd_pending && !rd_tag and b_rvalid = rd_pending && rd_tag.
  - The arbiter does not register read data.
- **Clients.** A client must not drop req before gnt. A new request may be presented in the cycle after gnt.

## Timing
- Grant latency: 0 cycles (gnt is combinational on req and the pointers).
- Write: RAM updates at the clk edge that ends the grant cycle.
- Read: rvalid and rdata are present in the cycle after gnt; throughput is one read per cycle.
- Back-to-back reads: alternate clients under continuous contention. A single requester may read every cycle.
- **Reset values:**
  - wptr = 1, rptr = 1.
  - rd_pending = 0, rd_tag = 0.
  - a_rvalid = b_rvalid = 0.
  - a_gnt = b_gnt = 0 and ram_we = 0 while rst_n = 0, because grants are gated by rst_n.
- **Reset mid-operation:** an in-flight read is dropped, with no rvalid after reset deasserts. An in-progress write is not performed if rst_n is low at the edge.
- **Write then read, same address:** a read granted in the cycle after a write returns the new data.

## Structure
- No shared package needed; ADDR_W is a localparam.
- One natural sub-module, rr_arb2: inputs req[1:0] and last; output onehot gnt[1:0]. It is instantiated twice (write port, read port), and the pointer registers live in the parent.
- The RAM is instantiated by the parent design alongside this block, not inside it.

## Test plan
1. **Reset.** Hold rst_n = 0 with a_req = b_req = 1 → a_gnt = b_gnt = 0, ram_we = 0, rvalid = 0. Release → first write contention grants A.
2. **Write contention.** A writes addr 3 = 0x11 and B writes addr 5 = 0x22, both held → A granted cycle 0, B cycle 1, ram_we high both cycles. Then read 3 → 0x11 and read 5 → 0x22.
3. **Read contention.** A and B read continuously → grants alternate A, B, A, B. Each client's rvalid follows its own gnt by 1 cycle, and rdata matches the stored word.
4. **Collision.** A writes addr 2 = 0x5A while B reads addr 2 → a_gnt = 1, b_gnt = 0. B is granted next cycle, and b_rvalid the cycle after shows 0x5A.
5. **Parallel.** A writes addr 1 while B reads addr 6 → both granted the same cycle; b_rvalid next cycle.
6. **Reset mid-read.** Grant a B read, then assert rst_n = 0 before the next edge → b_rvalid never asserts; pointers return to 1.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the two-client RAM port arbiter.
// Client identifiers double as the round-robin pointer encoding.
package ram_port_arbiter_pkg;

  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_e;

  function automatic client_e gnt_to_client(input logic [1:0] gnt);
    return gnt[1] ? CLIENT_B : CLIENT_A;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Client and RAM-side signal bundle for ram_port_arbiter.
// The slave modport is the arbiter's view; master is the clients/RAM view.
interface ram_port_arbiter_if #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 8
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              a_req;
  logic              b_req;
  logic              a_we;
  logic              b_we;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [SIZE-1:0]   a_wdata;
  logic [SIZE-1:0]   b_wdata;
  logic              a_gnt;
  logic              b_gnt;
  logic              a_rvalid;
  logic              b_rvalid;
  logic [SIZE-1:0]   a_rdata;
  logic [SIZE-1:0]   b_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [SIZE-1:0]   ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [SIZE-1:0]   ram_rdata;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
    input  ram_rdata,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
    output ram_we, ram_waddr, ram_wdata, ram_raddr
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
    output ram_rdata,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
    input  ram_we, ram_waddr, ram_wdata, ram_raddr
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on contention, grants the client that
// did not win last time. Pointer state is held by the parent.
module rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  client_e    last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == CLIENT_A) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one simple dual-port RAM (registered read) between clients A and B,
// arbitrating write and read ports independently and routing read returns.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  ram_port_arbiter_if.slave bus
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]        wr_req;
  logic [1:0]        rd_req;
  logic [1:0]        wr_gnt;
  logic [1:0]        rd_cand;
  logic [1:0]        rd_gnt;
  logic [ADDR_W-1:0] cand_raddr;
  logic              collide;

  client_e wptr_q, wptr_d;
  client_e rptr_q, rptr_d;
  client_e rd_tag_q, rd_tag_d;
  logic    rd_pending_q, rd_pending_d;

  // Gating with rst_n keeps grants and RAM writes off while reset is held.
  always_comb begin
    wr_req = {bus.b_req & bus.b_we, bus.a_req & bus.a_we} & {2{rst_n}};
    rd_req = {bus.b_req & ~bus.b_we, bus.a_req & ~bus.a_we} & {2{rst_n}};
  end

  rr_arb2 u_wr_arb (
    .req  (wr_req),
    .last (wptr_q),
    .gnt  (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .req  (rd_req),
    .last (rptr_q),
    .gnt  (rd_cand)
  );

  // A read hitting the address being written this cycle yields to the write.
  always_comb begin
    bus.ram_we    = |wr_gnt;
    bus.ram_waddr = wr_gnt[1] ? bus.b_addr  : bus.a_addr;
    bus.ram_wdata = wr_gnt[1] ? bus.b_wdata : bus.a_wdata;
    cand_raddr    = rd_cand[1] ? bus.b_addr : bus.a_addr;
    collide       = (|wr_gnt) && (|rd_cand) && (cand_raddr == bus.ram_waddr);
    rd_gnt        = collide ? 2'b00 : rd_cand;
    bus.ram_raddr = rd_gnt[1] ? bus.b_addr : bus.a_addr;
    bus.a_gnt     = wr_gnt[0] | rd_gnt[0];
    bus.b_gnt     = wr_gnt[1] | rd_gnt[1];
  end

  always_comb begin
    wptr_d       = (|wr_gnt) ? gnt_to_client(wr_gnt) : wptr_q;
    rptr_d       = (|rd_gnt) ? gnt_to_client(rd_gnt) : rptr_q;
    rd_pending_d = |rd_gnt;
    rd_tag_d     = gnt_to_client(rd_gnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= CLIENT_B;
      rptr_q       <= CLIENT_B;
      rd_pending_q <= 1'b0;
      rd_tag_q     <= CLIENT_A;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      rd_pending_q <= rd_pending_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  always_comb begin
    bus.a_rvalid = rd_pending_q && (rd_tag_q == CLIENT_A);
    bus.b_rvalid = rd_pending_q && (rd_tag_q == CLIENT_B);
    bus.a_rdata  = bus.ram_rdata;
    bus.b_rdata  = bus.ram_rdata;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed, table-driven bench for ram_port_arbiter with a behavioural
// registered-read RAM model attached to the RAM-side signals.
module tb_ram_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;

  ram_port_arbiter_if #(.SIZE(8), .DEPTH(8)) bus ();

  ram_port_arbiter #(.SIZE(8), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [8];

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_raddr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a_req;
    logic       a_we;
    logic [2:0] a_addr;
    logic [7:0] a_wdata;
    logic       b_req;
    logic       b_we;
    logic [2:0] b_addr;
    logic [7:0] b_wdata;
    logic       e_agnt;
    logic       e_bgnt;
    logic       e_we;
    logic [2:0] e_waddr;
    logic [7:0] e_wdata;
    logic       e_arv;
    logic       e_brv;
    logic [7:0] e_rdata;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  task automatic drive(input logic ar, input logic aw, input logic [2:0] aa, input logic [7:0] ad,
                       input logic br, input logic bw, input logic [2:0] ba, input logic [7:0] bd);
    bus.a_req   = ar;
    bus.a_we    = aw;
    bus.a_addr  = aa;
    bus.a_wdata = ad;
    bus.b_req   = br;
    bus.b_we    = bw;
    bus.b_addr  = ba;
    bus.b_wdata = bd;
  endtask

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    drive(v.a_req, v.a_we, v.a_addr, v.a_wdata, v.b_req, v.b_we, v.b_addr, v.b_wdata);
  endtask

  task automatic check_output(input vec_t v, input int idx);
    check_value($sformatf("row%0d a_gnt", idx), 32'(bus.a_gnt), 32'(v.e_agnt));
    check_value($sformatf("row%0d b_gnt", idx), 32'(bus.b_gnt), 32'(v.e_bgnt));
    check_value($sformatf("row%0d ram_we", idx), 32'(bus.ram_we), 32'(v.e_we));
    check_value($sformatf("row%0d a_rvalid", idx), 32'(bus.a_rvalid), 32'(v.e_arv));
    check_value($sformatf("row%0d b_rvalid", idx), 32'(bus.b_rvalid), 32'(v.e_brv));
    if (v.e_we) begin
      check_value($sformatf("row%0d ram_waddr", idx), 32'(bus.ram_waddr), 32'(v.e_waddr));
      check_value($sformatf("row%0d ram_wdata", idx), 32'(bus.ram_wdata), 32'(v.e_wdata));
    end
    if (v.e_arv) check_value($sformatf("row%0d a_rdata", idx), 32'(bus.a_rdata), 32'(v.e_rdata));
    if (v.e_brv) check_value($sformatf("row%0d b_rdata", idx), 32'(bus.b_rdata), 32'(v.e_rdata));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    //           aR aW aAd aWd    bR bW bAd bWd    gA gB we wAd wD    aRv bRv rD
    vecs[0]  = '{1, 1, 3, 8'h11, 1, 1, 5, 8'h22, 1, 0, 1, 3, 8'h11, 0, 0, 8'h00};
    vecs[1]  = '{0, 0, 0, 8'h00, 1, 1, 5, 8'h22, 0, 1, 1, 5, 8'h22, 0, 0, 8'h00};
    vecs[2]  = '{1, 0, 3, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00};
    vecs[3]  = '{0, 0, 0, 8'h00, 1, 0, 5, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 8'h11};
    vecs[4]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 8'h22};
    vecs[5]  = '{1, 0, 3, 8'h00, 1, 0, 5, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00};
    vecs[6]  = '{1, 0, 3, 8'h00, 1, 0, 5, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 8'h11};
    vecs[7]  = '{1, 0, 3, 8'h00, 1, 0, 5, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 8'h22};
    vecs[8]  = '{1, 0, 3, 8'h00, 1, 0, 5, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 8'h11};
    vecs[9]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 8'h22};
    vecs[10] = '{1, 1, 2, 8'h5A, 1, 0, 2, 8'h00, 1, 0, 1, 2, 8'h5A, 0, 0, 8'h00};
    vecs[11] = '{0, 0, 0, 8'h00, 1, 0, 2, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00};
    vecs[12] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 8'h5A};
    vecs[13] = '{1, 1, 1, 8'h77, 1, 0, 6, 8'h00, 1, 1, 1, 1, 8'h77, 0, 0, 8'h00};
    vecs[14] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 8'h00};
    vecs[15] = '{1, 1, 6, 8'h66, 0, 0, 0, 8'h00, 1, 0, 1, 6, 8'h66, 0, 0, 8'h00};
    vecs[16] = '{1, 0, 6, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00};
    vecs[17] = '{1, 0, 1, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 8'h66};
    vecs[18] = '{1, 0, 6, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 8'h77};
    vecs[19] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 8'h66};
    vecs[20] = '{1, 1, 0, 8'h01, 1, 1, 7, 8'h02, 0, 1, 1, 7, 8'h02, 0, 0, 8'h00};
    vecs[21] = '{1, 1, 0, 8'h01, 0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h01, 0, 0, 8'h00};
    vecs[22] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00};

    // Reset held with both clients requesting writes.
    rst_n = 1'b0;
    drive(1, 1, 3, 8'h11, 1, 1, 5, 8'h22);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_value("reset a_gnt", 32'(bus.a_gnt), 0);
    check_value("reset b_gnt", 32'(bus.b_gnt), 0);
    check_value("reset ram_we", 32'(bus.ram_we), 0);
    check_value("reset a_rvalid", 32'(bus.a_rvalid), 0);
    check_value("reset b_rvalid", 32'(bus.b_rvalid), 0);

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) rst_n = 1'b1;
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output(vecs[i], i);
    end

    // Reset lands while a B read is granted; a write is also held during reset.
    @(posedge clk);
    #1;
    drive(0, 0, 0, 8'h00, 1, 0, 5, 8'h00);
    @(negedge clk);
    check_value("midrd b_gnt before reset", 32'(bus.b_gnt), 1);
    #2;
    rst_n = 1'b0;
    drive(1, 1, 4, 8'h99, 0, 0, 0, 8'h00);
    #1;
    check_value("midrd b_gnt gated", 32'(bus.b_gnt), 0);
    check_value("midrd a_gnt gated", 32'(bus.a_gnt), 0);
    check_value("midrd ram_we gated", 32'(bus.ram_we), 0);
    @(posedge clk);
    #1;
    check_value("midrd b_rvalid in reset", 32'(bus.b_rvalid), 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check_value("midrd b_rvalid after release", 32'(bus.b_rvalid), 0);
    check_value("midrd a_rvalid after release", 32'(bus.a_rvalid), 0);

    // Pointers back at 1: A wins both write and read contention.
    @(posedge clk);
    #1;
    drive(1, 1, 0, 8'h33, 1, 1, 7, 8'h44);
    @(negedge clk);
    check_value("post-reset wr a_gnt", 32'(bus.a_gnt), 1);
    check_value("post-reset wr b_gnt", 32'(bus.b_gnt), 0);
    check_value("post-reset b_rvalid", 32'(bus.b_rvalid), 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 8'h00, 1, 1, 7, 8'h44);
    @(negedge clk);
    check_value("post-reset wr2 b_gnt", 32'(bus.b_gnt), 1);
    @(posedge clk);
    #1;
    drive(1, 0, 4, 8'h00, 1, 0, 0, 8'h00);
    @(negedge clk);
    check_value("post-reset rd a_gnt", 32'(bus.a_gnt), 1);
    check_value("post-reset rd b_gnt", 32'(bus.b_gnt), 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 8'h00, 1, 0, 0, 8'h00);
    @(negedge clk);
    check_value("post-reset rd2 b_gnt", 32'(bus.b_gnt), 1);
    check_value("post-reset a_rvalid", 32'(bus.a_rvalid), 1);
    check_value("reset-blocked write a_rdata", 32'(bus.a_rdata), 32'h00);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    @(negedge clk);
    check_value("post-reset b_rvalid final", 32'(bus.b_rvalid), 1);
    check_value("post-reset b_rdata final", 32'(bus.b_rdata), 32'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
